// File: rtl/reg_native_if2apb_mslv.sv
// reg_native_if2apb_mslv
// Bridges one native register requester onto SLV_NUM APB3 completers. The
// completer is chosen by addr[SEL_LSB +: SEL_W]. Malformed commands and
// out-of-range selects are answered locally, without an APB cycle.
// The native response (ack_vld, rd_data, err) is fully registered.
// Optional feature: define REG_NATIVE_IF2APB_TIMEOUT_EN to abort an ACCESS
// phase that waits TIMEOUT_CYCLES cycles without pready.
module reg_native_if2apb_mslv #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int SLV_NUM        = 4,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_vld,
  output logic                          ack_vld,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          err,
  output logic [SLV_NUM-1:0]            psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [DATA_WIDTH-1:0]         pwdata,
  input  logic [SLV_NUM*DATA_WIDTH-1:0] prdata,
  input  logic [SLV_NUM-1:0]            pready,
  input  logic [SLV_NUM-1:0]            pslverr
);

  localparam int SEL_W = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
  localparam logic [SLV_NUM-1:0] SEL_ONE = SLV_NUM'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]            state;
  logic [SEL_W-1:0]      idx;
  logic [SEL_W-1:0]      req_idx;
  logic                  cmd_err;
  logic                  dec_err;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  tmo_abort;

  // Screening is evaluated on the live request so errors resolve at acceptance.
  assign req_idx = addr[SEL_LSB +: SEL_W];
  assign cmd_err = (wr_en == rd_en);
  assign dec_err = (32'(req_idx) >= SLV_NUM);

  // Only the latched completer's handshake and data are ever looked at.
  assign sel_ready = pready[idx];
  assign sel_err   = pslverr[idx];
  assign sel_rdata = prdata[int'(idx)*DATA_WIDTH +: DATA_WIDTH];

`ifdef REG_NATIVE_IF2APB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] tmo_cnt;

  // The limit is hit when this cycle's stall would bring the count to
  // TIMEOUT_CYCLES; a pready in that same cycle still completes normally.
  assign tmo_abort = !sel_ready && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count stalled ACCESS cycles; cleared while entering ACCESS from SETUP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == S_SETUP) begin
      tmo_cnt <= '0;
    end else if (state == S_ACCESS && !sel_ready) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_abort = 1'b0;
`endif

  // Transfer sequencing plus every registered APB and native output.
  // NOTE: state and outputs use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      psel    <= '0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      ack_vld <= 1'b0;
      rd_data <= '0;
      err     <= 1'b0;
    end else begin
      ack_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_vld) begin
            paddr  <= addr;
            pwdata <= wr_data;
            pwrite <= wr_en;
            idx    <= req_idx;
            if (cmd_err || dec_err) begin
              state   <= S_RESP;
              ack_vld <= 1'b1;
              err     <= 1'b1;
              rd_data <= '0;
            end else begin
              state <= S_SETUP;
              psel  <= SEL_ONE << req_idx;
            end
          end
        end
        S_SETUP: begin
          state   <= S_ACCESS;
          penable <= 1'b1;
        end
        S_ACCESS: begin
          if (sel_ready) begin
            state   <= S_RESP;
            psel    <= '0;
            penable <= 1'b0;
            ack_vld <= 1'b1;
            err     <= sel_err;
            rd_data <= pwrite ? '0 : sel_rdata;
          end else if (tmo_abort) begin
            state   <= S_RESP;
            psel    <= '0;
            penable <= 1'b0;
            ack_vld <= 1'b1;
            err     <= 1'b1;
            rd_data <= '0;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_native_if2apb_mslv.sv
// Bench for reg_native_if2apb_mslv: a 4-completer and a 3-completer instance
// share the APB-side stimulus. A transaction-level model predicts every
// output each cycle; directed transfers pin latencies and data by hand.
// Build with REG_NATIVE_IF2APB_TIMEOUT_EN to exercise the timeout path.
module tb_reg_native_if2apb_mslv;

  localparam int AW  = 64;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req4, req3, wr_en, rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [4*DW-1:0] prdata;
  logic [3:0]    pready, pslverr;

  logic          ack4, err4, pen4, pwr4;
  logic [DW-1:0] rd4, pwd4;
  logic [AW-1:0] paddr4;
  logic [3:0]    psel4;
  logic          ack3, err3, pen3, pwr3;
  logic [DW-1:0] rd3, pwd3;
  logic [AW-1:0] paddr3;
  logic [2:0]    psel3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_native_if2apb_mslv #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLV_NUM(4),
                           .SEL_LSB(12), .TIMEOUT_CYCLES(TMO)) dut4 (
    .clk(clk), .rst(rst), .req_vld(req4), .ack_vld(ack4), .wr_en(wr_en),
    .rd_en(rd_en), .addr(addr), .wr_data(wr_data), .rd_data(rd4), .err(err4),
    .psel(psel4), .penable(pen4), .pwrite(pwr4), .paddr(paddr4), .pwdata(pwd4),
    .prdata(prdata), .pready(pready), .pslverr(pslverr));

  reg_native_if2apb_mslv #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLV_NUM(3),
                           .SEL_LSB(12), .TIMEOUT_CYCLES(TMO)) dut3 (
    .clk(clk), .rst(rst), .req_vld(req3), .ack_vld(ack3), .wr_en(wr_en),
    .rd_en(rd_en), .addr(addr), .wr_data(wr_data), .rd_data(rd3), .err(err3),
    .psel(psel3), .penable(pen3), .pwrite(pwr3), .paddr(paddr3), .pwdata(pwd3),
    .prdata(prdata[3*DW-1:0]), .pready(pready[2:0]), .pslverr(pslverr[2:0]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Index 0 models the 4-completer instance, index 1 the 3-completer one.
  bit          m_busy [2];   // APB transfer outstanding (SETUP or ACCESS)
  bit          m_resp [2];   // response cycle
  int          m_age  [2];   // cycles since acceptance while busy
  int          m_tcnt [2];   // stalled ACCESS cycles
  int          m_idx  [2];
  bit          m_wr   [2];
  logic [63:0] m_addr [2];
  logic [31:0] m_wd   [2];
  logic [31:0] m_rd   [2];
  bit          m_err  [2];

  function automatic int nslv(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic logic req_of(input int d);
    return (d == 0) ? req4 : req3;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] = 0; m_resp[d] = 0; m_age[d] = 0; m_tcnt[d] = 0; m_idx[d] = 0;
        m_wr[d] = 0; m_addr[d] = '0; m_wd[d] = '0; m_rd[d] = '0; m_err[d] = 0;
      end else if (m_resp[d]) begin
        m_resp[d] = 0;
      end else if (!m_busy[d]) begin
        if (req_of(d)) begin
          m_addr[d] = addr;
          m_wd[d]   = wr_data;
          m_wr[d]   = wr_en;
          m_idx[d]  = int'(addr[13:12]);
          if (wr_en == rd_en || m_idx[d] >= nslv(d)) begin
            m_resp[d] = 1; m_rd[d] = '0; m_err[d] = 1;
          end else begin
            m_busy[d] = 1; m_age[d] = 1;
          end
        end
      end else if (m_age[d] == 1) begin
        m_age[d] = 2; m_tcnt[d] = 0;
      end else if (pready[m_idx[d]]) begin
        m_busy[d] = 0; m_resp[d] = 1;
        m_err[d]  = pslverr[m_idx[d]];
        m_rd[d]   = m_wr[d] ? 32'h0 : prdata[m_idx[d]*DW +: DW];
      end else begin
`ifdef REG_NATIVE_IF2APB_TIMEOUT_EN
        m_tcnt[d]++;
        if (m_tcnt[d] >= TMO) begin
          m_busy[d] = 0; m_resp[d] = 1; m_err[d] = 1; m_rd[d] = '0;
        end
`endif
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      string p;
      logic [3:0] e_psel;
      p = (d == 0) ? "d4" : "d3";
      e_psel = m_busy[d] ? (4'b0001 << m_idx[d]) : 4'b0000;
      check({p, ".psel"},    (d == 0) ? psel4 : {1'b0, psel3}, e_psel);
      check({p, ".penable"}, (d == 0) ? pen4 : pen3, m_busy[d] && m_age[d] >= 2);
      check({p, ".ack_vld"}, (d == 0) ? ack4 : ack3, m_resp[d]);
      check({p, ".paddr"},   (d == 0) ? paddr4 : paddr3, m_addr[d]);
      check({p, ".pwrite"},  (d == 0) ? pwr4 : pwr3, m_wr[d]);
      check({p, ".pwdata"},  (d == 0) ? pwd4 : pwd3, m_wd[d]);
      if (m_resp[d] || rst) begin
        check({p, ".rd_data"}, (d == 0) ? rd4 : rd3, m_resp[d] ? m_rd[d] : 32'h0);
        check({p, ".err"},     (d == 0) ? err4 : err3, m_resp[d] ? m_err[d] : 1'b0);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Called at a falling edge; the request is live for one cycle (cycle 0).
  // exp_lat < 0 means no ack may appear within the budget.
  task automatic issue(input string name, input int d, input bit w, input bit r,
                       input logic [63:0] a, input logic [31:0] wd,
                       input logic [3:0] rdy_mask, input int rdy_at,
                       input logic [3:0] noise, input int budget,
                       input logic [3:0] exp_psel1, input int exp_lat,
                       input logic [31:0] exp_rd, input bit exp_err);
    int lat;
    logic [31:0] got_rd;
    logic got_err;
    lat = -1; got_rd = '0; got_err = 1'b0;
    wr_en = w; rd_en = r; addr = a; wr_data = wd;
    if (d == 0) req4 = 1'b1; else req3 = 1'b1;
    pready = ((rdy_at == 0) ? rdy_mask : 4'b0) | noise;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      req4 = 1'b0; req3 = 1'b0;
      if (k == 1)
        check({name, ".psel@1"}, (d == 0) ? psel4 : {1'b0, psel3}, exp_psel1);
      if ((d == 0) ? ack4 : ack3) begin
        lat = k;
        got_rd  = (d == 0) ? rd4 : rd3;
        got_err = (d == 0) ? err4 : err3;
        break;
      end
      pready = ((k >= rdy_at) ? rdy_mask : 4'b0) | noise;
    end
    check({name, ".latency"}, 64'(lat), 64'(exp_lat));
    if (lat > 0) begin
      check({name, ".rd_data"}, got_rd, exp_rd);
      check({name, ".err"}, got_err, exp_err);
      pready = 4'b0; pslverr = 4'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req4 = 1'b0; req3 = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    addr = '0; wr_data = '0; pready = '0; pslverr = '0;
    prdata = {32'h0BAD_0003, 32'h2222_0002, 32'hDEAD_BEEF, 32'h1111_0000};
    repeat (3) @(negedge clk);
    check("reset.ack_vld", ack4, 1'b0);
    check("reset.psel", psel4, 4'b0000);
    rst = 1'b0;

    issue("wr0wait", 0, 1, 0, 64'h2010, 32'hA5A5_0001, 4'b0100, 0, 4'b0000, 20,
          4'b0100, 3, 32'h0, 1'b0);
    // Non-selected completers signal ready and error throughout; ignored.
    pslverr = 4'b1101;
    issue("rd3wait", 0, 0, 1, 64'h1004, 32'h0, 4'b0010, 5, 4'b1101, 20,
          4'b0010, 6, 32'hDEAD_BEEF, 1'b0);
    pslverr = 4'b1000;
    issue("slverr", 0, 0, 1, 64'h3008, 32'h0, 4'b1000, 2, 4'b0000, 20,
          4'b1000, 3, 32'h0BAD_0003, 1'b1);
    issue("cmd_none", 0, 0, 0, 64'h0000, 32'h5, 4'b0001, 0, 4'b0000, 20,
          4'b0000, 1, 32'h0, 1'b1);
    issue("dec3", 1, 1, 0, 64'h3000, 32'h7, 4'b0000, 0, 4'b0000, 20,
          4'b0000, 1, 32'h0, 1'b1);
    issue("cmd_both", 1, 1, 1, 64'h1000, 32'h8, 4'b0010, 0, 4'b0000, 20,
          4'b0000, 1, 32'h0, 1'b1);
    issue("d3wr", 1, 1, 0, 64'h2000, 32'h1234_5678, 4'b0100, 0, 4'b0000, 20,
          4'b0100, 3, 32'h0, 1'b0);
    issue("d3rd", 1, 0, 1, 64'h0040, 32'h0, 4'b0001, 3, 4'b0000, 20,
          4'b0001, 4, 32'h1111_0000, 1'b0);

`ifdef REG_NATIVE_IF2APB_TIMEOUT_EN
    issue("tmo", 0, 0, 1, 64'h0000, 32'h0, 4'b0001, 1000, 4'b0000, 40,
          4'b0001, 10, 32'h0, 1'b1);
    issue("tmo_rdywins", 0, 0, 1, 64'h0000, 32'h0, 4'b0001, 9, 4'b0000, 40,
          4'b0001, 10, 32'h1111_0000, 1'b0);
    issue("stall", 0, 0, 1, 64'h1000, 32'h0, 4'b0010, 1000, 4'b0000, 4,
          4'b0010, -1, 32'h0, 1'b0);
`else
    issue("hang", 0, 0, 1, 64'h1000, 32'h0, 4'b0010, 1000, 4'b0000, 100,
          4'b0010, -1, 32'h0, 1'b0);
`endif
    check("stall.penable", pen4, 1'b1);
    check("stall.psel", psel4, 4'b0010);

    // Asynchronous reset in the middle of ACCESS, away from a clock edge.
    #2 rst = 1'b1;
    #1;
    check("arst.psel", psel4, 4'b0000);
    check("arst.penable", pen4, 1'b0);
    check("arst.ack_vld", ack4, 1'b0);
    check("arst.paddr", paddr4, 64'h0);
    pready = 4'b0;
    @(negedge clk);
    rst = 1'b0;
    issue("post_rst", 0, 1, 0, 64'h2010, 32'hA5A5_0002, 4'b0100, 0, 4'b0000, 20,
          4'b0100, 3, 32'h0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_native_if2apb_mslv.md
Name: reg_native_if2apb_mslv

Overview:
- Successor native-register-interface to APB bridge: one native requester fanned out to SLV_NUM APB3 completers.
- Completer is selected by an address-field decode.
- Adds protections:
  - decode and command errors answered locally, with no APB cycle issued;
  - registered single-cycle response;
  - optional access timeout.
- Sits between the register-block native bus and a cluster of APB register files.

Parameters:
- ADDR_WIDTH, 64, native/APB address width.
- DATA_WIDTH, 32, data width.
- SLV_NUM, 4, number of APB completers (1..16).
- SEL_LSB, 12, LSB of completer-select field in addr. Field width SEL_W = max(1, clog2(SLV_NUM)).
- TIMEOUT_CYCLES, 255, ACCESS-phase cycle limit (8-bit counter minimum; used only with timeout macro).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_vld  in  1  request strobe, sampled only in IDLE.
- ack_vld  out  1  one-cycle response pulse.
- wr_en  in  1  write command.
- rd_en  in  1  read command.
- addr  in  ADDR_WIDTH  request address.
- wr_data  in  DATA_WIDTH  write data.
- rd_data  out  DATA_WIDTH  read data, valid with ack_vld.
- err  out  1  error flag, valid with ack_vld.
- psel  out  SLV_NUM  one-hot completer select.
- penable  out  1  APB access phase.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address (full addr passed unmodified).
- pwdata  out  DATA_WIDTH  APB write data.
- prdata  in  SLV_NUM*DATA_WIDTH  packed read data; completer i at [i*DATA_WIDTH +: DATA_WIDTH].
- pready  in  SLV_NUM  per-completer ready.
- pslverr  in  SLV_NUM  per-completer error.

Behaviour:
- Reset, asynchronous, effective immediately even mid-transfer:
  - state=IDLE;
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0;
  - ack_vld=0, rd_data=0, err=0;
  - timeout counter=0.
- Acceptance:
  - Request accepted when state==IDLE and req_vld=1.
  - On acceptance, latch addr, wr_data, wr_en and slave index idx=addr[SEL_LSB +: SEL_W].
  - req_vld outside IDLE is ignored; requester must wait for ack_vld before issuing the next request.
- Error screening at acceptance:
  - Command error: wr_en==rd_en (both 0 or both 1).
  - Decode error: idx>=SLV_NUM.
  - Either error -> state RESP directly, no psel asserted. Response: ack_vld=1, err=1, rd_data=0 on the next cycle (latency 1).
- States:
  - IDLE -> SETUP: valid request.
  - IDLE -> RESP: screened error.
  - SETUP -> ACCESS: unconditional. In SETUP, psel[idx]=1, penable=0, pwrite/paddr/pwdata from the latch.
  - ACCESS: psel[idx]=1, penable=1.
    - Stays in ACCESS while pready[idx]=0.
    - On pready[idx]=1, capture prdata slice idx into rd_data (reads only; writes give rd_data=0) and err=pslverr[idx], then go to RESP.
  - RESP: psel=0, penable=0, ack_vld=1 for exactly this cycle, then -> IDLE. New request acceptance is possible on the following cycle.
- Signals not addressed by idx:
  - pready, pslverr and prdata of non-selected completers are ignored.
  - psel bits other than idx are always 0.
- paddr, pwrite, pwdata hold their last values outside a transfer; they are not cleared.
- Latency, zero-wait completer: request at cycle 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> ack_vld cycle 3. Each pready wait state adds 1 cycle.
- Back-to-back transfers: minimum 4 cycles per APB transfer and 2 cycles per errored request.
- ack_vld, rd_data and err are all registered; no combinational path from APB inputs to native outputs.

Optional Feature:
- Macro: REG_NATIVE_IF2APB_TIMEOUT_EN.
- When defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle with pready[idx]=0.
  - When the count reaches TIMEOUT_CYCLES, the access is aborted: psel and penable drop to 0 the next cycle, the bridge goes to RESP with err=1 and rd_data=0.
  - A pready arriving in the same cycle the limit is hit wins; it is treated as a normal completion.
- When undefined: no counter logic; ACCESS waits indefinitely for pready.

Test Plan:
- Zero-wait write: SLV_NUM=4, SEL_LSB=12, addr=0x2010, wr_en=1, wr_data=0xA5A5_0001, pready[2]=1 -> psel=4'b0100 cycle 1, penable cycle 2, ack_vld cycle 3, err=0.
- Read with 3 wait states: addr=0x1004, rd_en=1, pready[1] high on the 4th ACCESS cycle with prdata slice1=0xDEAD_BEEF -> ack_vld cycle 6, rd_data=0xDEADBEEF, err=0.
- Completer error: read to slave 3 with pslverr[3]=1 at pready -> ack_vld with err=1.
- Screening: SLV_NUM=3, addr=0x3000 -> ack_vld next cycle, err=1, psel never set. Also wr_en=rd_en=1 -> same result.
- Timeout (macro on, TIMEOUT_CYCLES=8): pready held 0 -> psel drops after 8 ACCESS cycles, ack_vld with err=1, rd_data=0. With macro off, the bridge stays in ACCESS for 100 cycles.
- Reset mid-ACCESS: assert rst during ACCESS -> psel, penable and ack_vld go to 0 asynchronously. After release, a fresh request completes normally.
